// File: rtl/blake2_pkg.sv
// Shared constants, packer state encoding and beat masking helper for the
// BLAKE2b message packer.
package blake2_pkg;

  localparam int BLK_BYTES     = 128;
  localparam int BEAT_BYTES    = 8;
  localparam int BEATS_PER_BLK = 16;
  localparam int T_W           = 128;

  typedef enum logic [1:0] {
    ST_FILL,
    ST_HOLD,
    ST_SEND
  } pack_state_t;

  // Keep the low 'bytes' bytes of a beat and zero the rest.
  function automatic logic [8*BEAT_BYTES-1:0] mask_beat(
    input logic [8*BEAT_BYTES-1:0] data,
    input logic [3:0]              bytes
  );
    logic [8*BEAT_BYTES-1:0] keep;
    keep = '0;
    for (int i = 0; i < BEAT_BYTES; i++) begin
      if (4'(i) < bytes) keep[8*i +: 8] = 8'hff;
    end
    return data & keep;
  endfunction

endpackage

// File: rtl/blake2b_beat_skid.sv
// One-beat holding register: parks the beat that arrives while a full block
// waits to learn whether it is the final one.
module blake2b_beat_skid
  import blake2_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic                    take,
  input  logic [8*BEAT_BYTES-1:0] in_data,
  input  logic [3:0]              in_bytes,
  input  logic                    in_last,
  output logic                    full,
  output logic [8*BEAT_BYTES-1:0] data,
  output logic [3:0]              bytes,
  output logic                    last
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full  <= 1'b0;
      data  <= '0;
      bytes <= '0;
      last  <= 1'b0;
    end else if (load) begin
      full  <= 1'b1;
      data  <= in_data;
      bytes <= in_bytes;
      last  <= in_last;
    end else if (take) begin
      full  <= 1'b0;
    end
  end

endmodule

// File: rtl/blake2b_msg_packer.sv
// Packs 8-byte message beats into 128-byte BLAKE2b compression blocks with a
// running byte counter and final-block flag.
module blake2b_msg_packer
  import blake2_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    s_valid_i,
  output logic                    s_ready_o,
  input  logic [8*BEAT_BYTES-1:0] s_data_i,
  input  logic [3:0]              s_bytes_i,
  input  logic                    s_last_i,
  output logic                    blk_valid_o,
  input  logic                    blk_ready_i,
  output logic [8*BLK_BYTES-1:0]  blk_data_o,
  output logic [T_W-1:0]          blk_t_o,
  output logic                    blk_last_o
);

  pack_state_t             state_q, state_d;
  logic                    ready_en_q;
  logic [3:0]              idx_q;
  logic [8*BLK_BYTES-1:0]  data_q;
  logic [T_W-1:0]          t_q;
  logic                    last_q;

  logic                    accept, blk_fire, empty_last;
  logic [8*BEAT_BYTES-1:0] beat_masked;
  logic                    skid_load, skid_take, skid_full, skid_last;
  logic [8*BEAT_BYTES-1:0] skid_data;
  logic [3:0]              skid_bytes;

  assign s_ready_o   = ready_en_q && (state_q != ST_SEND);
  assign blk_valid_o = (state_q == ST_SEND);
  assign blk_data_o  = data_q;
  assign blk_t_o     = t_q;
  assign blk_last_o  = last_q;

  assign accept      = s_valid_i && s_ready_o;
  assign blk_fire    = blk_valid_o && blk_ready_i;
  assign empty_last  = s_last_i && (s_bytes_i == 4'd0);
  assign beat_masked = mask_beat(s_data_i, s_bytes_i);

  blake2b_beat_skid u_skid (
    .clk      (clk),
    .reset    (reset),
    .load     (skid_load),
    .take     (skid_take),
    .in_data  (beat_masked),
    .in_bytes (s_bytes_i),
    .in_last  (s_last_i),
    .full     (skid_full),
    .data     (skid_data),
    .bytes    (skid_bytes),
    .last     (skid_last)
  );

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d   = state_q;
    skid_load = 1'b0;
    skid_take = 1'b0;
    case (state_q)
      ST_FILL: begin
        if (accept) begin
          if (s_last_i)                              state_d = ST_SEND;
          else if (idx_q == 4'(BEATS_PER_BLK - 1))  state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (accept) begin
          state_d   = ST_SEND;
          skid_load = !empty_last;
        end
      end
      ST_SEND: begin
        if (blk_fire) begin
          skid_take = skid_full;
          // A held final beat completes the next block immediately.
          state_d   = (skid_full && skid_last) ? ST_SEND : ST_FILL;
        end
      end
      default: state_d = ST_FILL;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_FILL;
      ready_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ready_en_q <= 1'b1;
    end
  end

  // NOTE: the block buffer is reset because its contents are visible on the
  // block port and must read as zero after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q  <= '0;
      data_q <= '0;
      t_q    <= '0;
      last_q <= 1'b0;
    end else begin
      case (state_q)
        ST_FILL: begin
          if (accept) begin
            data_q[{idx_q, 6'd0} +: 64] <= beat_masked;
            t_q    <= t_q + {124'd0, s_bytes_i};
            idx_q  <= idx_q + 4'd1;
            last_q <= s_last_i;
          end
        end
        ST_HOLD: begin
          // The buffered block stays untouched; only its final flag is decided.
          if (accept) last_q <= empty_last;
        end
        ST_SEND: begin
          if (blk_fire) begin
            if (skid_take) begin
              data_q <= {{(8*(BLK_BYTES-BEAT_BYTES)){1'b0}}, skid_data};
              idx_q  <= 4'd1;
            end else begin
              data_q <= '0;
              idx_q  <= 4'd0;
            end
            t_q    <= (last_q ? '0 : t_q) + (skid_take ? {124'd0, skid_bytes} : '0);
            last_q <= skid_take && skid_last;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
